// File: rtl/lcd_frame_streamer_pkg.sv
// Shared opcodes, word format and FSM encoding for the ST7789V3 windowed frame writer.
package lcd_frame_streamer_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam int         DC_BIT    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR,
    ST_STREAM
  } state_t;

  function automatic logic [DC_BIT:0] mk_word(input logic dc, input logic [7:0] b);
    return {dc, b};
  endfunction

  // Address-set parameter n (1..4): start hi, start lo, end hi, end lo.
  function automatic logic [7:0] addr_param(input logic [2:0] n, input logic [15:0] s,
                                            input logic [15:0] e);
    case (n)
      3'd1:    return s[15:8];
      3'd2:    return s[7:0];
      3'd3:    return e[15:8];
      3'd4:    return e[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_pixel_packer.sv
// Turns 16-bit pixels into D/C=1 byte words (RGB565: 2 per pixel, RGB444: 3 per pair).
// Word register plus one pending word; a pixel is taken only when both will be free.
module lcd_pixel_packer
  import lcd_frame_streamer_pkg::*;
#(
  parameter int WORD_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode_444,
  input  logic                  pix_last,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [15:0]           pix_data,
  input  logic                  out_ready,
  output logic                  word_vld,
  output logic [WORD_WIDTH-1:0] word_dat,
  output logic                  word_last
);

  logic       take;
  logic       half;
  logic       pend_vld;
  logic       pend_last;
  logic [7:0] o_byte;
  logic [7:0] pend_byte;
  logic [3:0] nib;

  assign pix_ready = en && !pend_vld && (!word_vld || out_ready);
  assign take      = pix_valid && pix_ready;
  assign word_dat  = WORD_WIDTH'(mk_word(1'b1, o_byte));

  always_ff @(posedge clk) begin
    if (rst) begin
      word_vld  <= 1'b0;
      word_last <= 1'b0;
      o_byte    <= 8'h00;
      pend_vld  <= 1'b0;
      pend_last <= 1'b0;
      pend_byte <= 8'h00;
      half      <= 1'b0;
      nib       <= 4'h0;
    end else if (take) begin
      word_vld  <= 1'b1;
      word_last <= 1'b0;
      pend_last <= pix_last;
      if (!mode_444) begin
        o_byte    <= pix_data[15:8];
        pend_byte <= pix_data[7:0];
        pend_vld  <= 1'b1;
      end else if (!half) begin
        // First of a pair: B waits for the partner pixel unless this is the last one.
        o_byte    <= pix_data[11:4];
        pend_byte <= {pix_data[3:0], 4'h0};
        pend_vld  <= pix_last;
        half      <= !pix_last;
        nib       <= pix_data[3:0];
      end else begin
        o_byte    <= {nib, pix_data[11:8]};
        pend_byte <= pix_data[7:0];
        pend_vld  <= 1'b1;
        half      <= 1'b0;
      end
    end else if (word_vld && out_ready) begin
      word_vld  <= pend_vld;
      word_last <= pend_vld && pend_last;
      o_byte    <= pend_byte;
      pend_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Windowed ST7789V3 frame writer: CASET/RASET/RAMWR then packed pixel stream; first word
// one cycle after start, out_data held while out_ready is low, pixels stall with the packer.
module lcd_frame_streamer
  import lcd_frame_streamer_pkg::*;
#(
  parameter int COORD_WIDTH   = 9,
  parameter int MAX_X         = 239,
  parameter int MAX_Y         = 319,
  parameter int WORD_WIDTH    = 9,
  parameter int PIX_CNT_WIDTH = 2 * COORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic                   start,
  input  logic [COORD_WIDTH-1:0] x0,
  input  logic [COORD_WIDTH-1:0] x1,
  input  logic [COORD_WIDTH-1:0] y0,
  input  logic [COORD_WIDTH-1:0] y1,
  input  logic                   mode_444,
  input  logic                   continuous,
  input  logic                   stop,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [15:0]            pix_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   start_err
);

  localparam logic [COORD_WIDTH-1:0] MAX_X_C = COORD_WIDTH'(MAX_X);
  localparam logic [COORD_WIDTH-1:0] MAX_Y_C = COORD_WIDTH'(MAX_Y);

  state_t                   state;
  logic [2:0]               idx;
  logic                     cmd_vld;
  logic [WORD_WIDTH-1:0]    cmd_dat;
  logic [COORD_WIDTH-1:0]   x0_l, x1_l, y0_l, y1_l;
  logic                     m444_l, cont_l, stop_flag;
  logic [PIX_CNT_WIDTH-1:0] npix, pix_cnt, w_span, h_span, npix_calc;
  logic [15:0]              win_s, win_e;
  logic                     bad, cmd_acc, pix_take, pix_en, pix_last, frame_end;
  logic                     pk_vld, pk_last;
  logic [WORD_WIDTH-1:0]    pk_dat;

  assign bad       = (x1 < x0) || (y1 < y0) || (x1 > MAX_X_C) || (y1 > MAX_Y_C);
  assign w_span    = PIX_CNT_WIDTH'(x1 - x0) + PIX_CNT_WIDTH'(1);
  assign h_span    = PIX_CNT_WIDTH'(y1 - y0) + PIX_CNT_WIDTH'(1);
  assign npix_calc = w_span * h_span;
  assign win_s     = (state == ST_RASET) ? 16'(y0_l) : 16'(x0_l);
  assign win_e     = (state == ST_RASET) ? 16'(y1_l) : 16'(x1_l);

  assign cmd_acc   = cmd_vld && out_ready;
  assign pix_take  = pix_valid && pix_ready;
  assign pix_en    = (state == ST_STREAM) && (pix_cnt != npix);
  assign pix_last  = (pix_cnt == npix - PIX_CNT_WIDTH'(1));
  assign frame_end = (state == ST_STREAM) && pk_vld && pk_last && out_ready;

  assign out_valid  = cmd_vld || pk_vld;
  assign out_data   = cmd_vld ? cmd_dat : (pk_vld ? pk_dat : '0);
  assign busy       = (state != ST_IDLE);
  assign frame_done = frame_end;

  lcd_pixel_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .en        (pix_en),
    .mode_444  (m444_l),
    .pix_last  (pix_last),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .out_ready (out_ready),
    .word_vld  (pk_vld),
    .word_dat  (pk_dat),
    .word_last (pk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      cmd_vld   <= 1'b0;
      cmd_dat   <= '0;
      x0_l      <= '0;
      x1_l      <= '0;
      y0_l      <= '0;
      y1_l      <= '0;
      m444_l    <= 1'b0;
      cont_l    <= 1'b0;
      stop_flag <= 1'b0;
      npix      <= '0;
      pix_cnt   <= '0;
      start_err <= 1'b0;
    end else begin
      start_err <= 1'b0;
      if (stop && state != ST_IDLE) stop_flag <= 1'b1;
      if (pix_take) pix_cnt <= pix_cnt + PIX_CNT_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if (start && init_done) begin
            if (bad) begin
              start_err <= 1'b1;
            end else begin
              state     <= ST_CASET;
              x0_l      <= x0;
              x1_l      <= x1;
              y0_l      <= y0;
              y1_l      <= y1;
              m444_l    <= mode_444;
              cont_l    <= continuous;
              npix      <= npix_calc;
              pix_cnt   <= '0;
              stop_flag <= 1'b0;
              idx       <= 3'd0;
              cmd_vld   <= 1'b1;
              cmd_dat   <= WORD_WIDTH'(mk_word(1'b0, CMD_CASET));
            end
          end
        end
        ST_CASET, ST_RASET: begin
          if (cmd_acc) begin
            if (idx == 3'd4) begin
              idx <= 3'd0;
              if (state == ST_CASET) begin
                state   <= ST_RASET;
                cmd_dat <= WORD_WIDTH'(mk_word(1'b0, CMD_RASET));
              end else begin
                state   <= ST_RAMWR;
                cmd_dat <= WORD_WIDTH'(mk_word(1'b0, CMD_RAMWR));
              end
            end else begin
              idx     <= idx + 3'd1;
              cmd_dat <= WORD_WIDTH'(mk_word(1'b1, addr_param(idx + 3'd1, win_s, win_e)));
            end
          end
        end
        ST_RAMWR: begin
          if (cmd_acc) begin
            state   <= ST_STREAM;
            cmd_vld <= 1'b0;
            pix_cnt <= '0;
          end
        end
        ST_STREAM: begin
          if (frame_end) begin
            pix_cnt <= '0;
            // A stop arriving with the last word still ends the run.
            if (cont_l && !stop_flag && !stop) begin
              state   <= ST_RAMWR;
              cmd_vld <= 1'b1;
              cmd_dat <= WORD_WIDTH'(mk_word(1'b0, CMD_RAMWR));
            end else begin
              state     <= ST_IDLE;
              stop_flag <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scoreboard bench for lcd_frame_streamer: directed windows and pixels, expected words queued
// by the stimulus, popped and compared by a monitor on every accepted output word.
module tb_lcd_frame_streamer;

  typedef struct packed {
    logic       last;
    logic [8:0] dat;
  } exp_t;

  logic       clk, rst, init_done, start, mode_444, continuous, stop;
  logic [8:0] x0, x1, y0, y1;
  logic       pix_valid, pix_ready, out_valid, out_ready, busy, frame_done, start_err;
  logic [15:0] pix_data;
  logic [8:0] out_data;

  exp_t       exp_q[$];
  logic [8:0] wl[$];
  int tests = 0, fails = 0;
  int acc_cnt = 0, done_cnt = 0, err_cnt = 0;
  int stall_w1 = -1, stall_w2 = -1;
  int base_done, base_err, base_acc;

  lcd_frame_streamer dut (
    .clk(clk), .rst(rst), .init_done(init_done), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .mode_444(mode_444), .continuous(continuous),
    .stop(stop), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .frame_done(frame_done), .start_err(start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_wl(input bit mark_last);
    exp_t e;
    for (int i = 0; i < wl.size(); i++) begin
      e.dat  = wl[i];
      e.last = mark_last && (i == wl.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int ax0, input int ax1, input int ay0, input int ay1,
                          input bit m444, input bit cont);
    @(negedge clk);
    x0 = 9'(ax0); x1 = 9'(ax1); y0 = 9'(ay0); y1 = 9'(ay1);
    mode_444 = m444; continuous = cont; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    for (int n = 0; n < 400; n++) begin
      #2;
      ok = pix_ready;
      @(negedge clk);
      if (ok) break;
    end
    pix_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL pix_timeout: pixel %0h never taken", d);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0 && !busy) break;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  // Monitor: drives out_ready (with scheduled 3-cycle stalls) and scores every accepted word.
  initial begin : monitor
    int   stall_left, last_stalled;
    bit   prev_hold;
    logic [8:0] prev_dat;
    exp_t e;
    stall_left = 0; last_stalled = -1; prev_hold = 1'b0; prev_dat = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid && !rst && stall_left == 0 && last_stalled != acc_cnt &&
          (acc_cnt == stall_w1 || acc_cnt == stall_w2)) begin
        stall_left   = 3;
        last_stalled = acc_cnt;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, prev_dat);
        end
        if (out_valid && !out_ready) check("pix_ready_while_full", pix_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_word: got %0h, expected no word", out_data);
          end else begin
            e = exp_q.pop_front();
            check("word", out_data, e.dat);
            check("frame_done_on_last", frame_done, e.last);
          end
          acc_cnt++;
        end else if (frame_done) begin
          check("spurious_frame_done", frame_done, 0);
        end
        if (frame_done) done_cnt++;
        if (start_err) err_cnt++;
        prev_hold = out_valid && !out_ready;
        prev_dat  = out_data;
      end
    end
  end

  initial begin : stim
    rst = 1'b1; init_done = 1'b0; start = 1'b0; stop = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; mode_444 = 1'b0; continuous = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_start_err", start_err, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0; init_done = 1'b1;

    // 1: 2x1 window, RGB565
    base_done = done_cnt;
    wl = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
           9'h02C, 9'h1F8, 9'h100, 9'h100, 9'h11F};
    push_wl(1);
    do_start(0, 1, 0, 0, 0, 0);
    check("t1_busy_on_start", busy, 1);
    send_pix(16'hF800);
    send_pix(16'h001F);
    wait_idle("t1");
    check("t1_frames", done_cnt - base_done, 1);

    // 2: 3x1 window, RGB444 with odd pixel count
    base_done = done_cnt;
    wl = '{9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10C, 9'h02B, 9'h100, 9'h105, 9'h100, 9'h105,
           9'h02C, 9'h1AB, 9'h1CD, 9'h1EF, 9'h112, 9'h130};
    push_wl(1);
    do_start(10, 12, 5, 5, 1, 0);
    send_pix(16'h0ABC);
    send_pix(16'h0DEF);
    send_pix(16'h0123);
    wait_idle("t2");
    check("t2_frames", done_cnt - base_done, 1);

    // 3: stalls mid-CASET and mid-STREAM
    base_done = done_cnt;
    stall_w1 = acc_cnt + 2;
    stall_w2 = acc_cnt + 13;
    wl = '{9'h02A, 9'h100, 9'h102, 9'h100, 9'h103, 9'h02B, 9'h101, 9'h101, 9'h101, 9'h101,
           9'h02C, 9'h112, 9'h134, 9'h1AB, 9'h1CD};
    push_wl(1);
    do_start(2, 3, 257, 257, 0, 0);
    send_pix(16'h1234);
    send_pix(16'hABCD);
    wait_idle("t3");
    check("t3_frames", done_cnt - base_done, 1);
    stall_w1 = -1; stall_w2 = -1;

    // 4: rejected starts and init_done gating
    base_err = err_cnt; base_acc = acc_cnt;
    do_start(6, 5, 0, 0, 0, 0);
    check("t4_err_x1_lt_x0", start_err, 1);
    check("t4_busy_reject", busy, 0);
    @(negedge clk);
    check("t4_err_one_cycle", start_err, 0);
    do_start(0, 240, 0, 0, 0, 0);
    check("t4_err_x1_gt_max", start_err, 1);
    do_start(0, 0, 0, 320, 0, 0);
    check("t4_err_y1_gt_max", start_err, 1);
    init_done = 1'b0;
    do_start(0, 1, 0, 0, 0, 0);
    check("t4_no_err_init_low", start_err, 0);
    check("t4_busy_init_low", busy, 0);
    repeat (3) @(negedge clk);
    check("t4_still_idle", busy, 0);
    check("t4_no_words", acc_cnt - base_acc, 0);
    check("t4_err_count", err_cnt - base_err, 3);
    init_done = 1'b1;

    // 4b: window at the maximum legal corner is accepted
    wl = '{9'h02A, 9'h100, 9'h1EF, 9'h100, 9'h1EF, 9'h02B, 9'h101, 9'h13F, 9'h101, 9'h13F,
           9'h02C, 9'h180, 9'h101};
    push_wl(1);
    do_start(239, 239, 319, 319, 0, 0);
    send_pix(16'h8001);
    wait_idle("t4b");

    // 5: continuous 1x1, stop during frame 2
    base_done = done_cnt;
    wl = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
           9'h02C, 9'h15A, 9'h15A};
    push_wl(1);
    wl = '{9'h02C, 9'h10F, 9'h10F};
    push_wl(1);
    do_start(0, 0, 0, 0, 0, 1);
    send_pix(16'h5A5A);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      #3;
      if (done_cnt != base_done) break;
    end
    check("t5_first_frame", done_cnt - base_done, 1);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    send_pix(16'h0F0F);
    wait_idle("t5");
    repeat (5) @(negedge clk);
    check("t5_frames", done_cnt - base_done, 2);
    check("t5_stays_idle", busy, 0);

    // 6: reset with a half-packed RGB444 pair, then full replay
    wl = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
           9'h02C, 9'h1AB};
    push_wl(0);
    do_start(0, 1, 0, 0, 1, 0);
    send_pix(16'h0ABC);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) break;
    end
    check("t6_pre_reset_drained", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pix_ready", pix_ready, 0);
    base_done = done_cnt;
    wl = '{9'h02A, 9'h100, 9'h101, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h102, 9'h100, 9'h102,
           9'h02C, 9'h145, 9'h160};
    push_wl(1);
    do_start(1, 1, 2, 2, 1, 0);
    send_pix(16'h0456);
    wait_idle("t6");
    check("t6_frames", done_cnt - base_done, 1);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
